// File: rtl/hist_lut_builder_pkg.sv
// Shared types and sizes for the histogram accumulator, LUT builder and remap stage.
package hist_pkg;

    localparam int unsigned NUM_BINS  = 256;
    localparam int unsigned BIN_W     = 16;
    localparam int unsigned CDF_W     = 24;
    localparam int unsigned PIX_W     = 8;
    localparam int unsigned NUM_W     = 32;
    localparam int unsigned MAX_LEVEL = 255;

    typedef logic [BIN_W-1:0] bin_t;
    typedef logic [CDF_W-1:0] cdf_t;
    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [2:0] {
        IDLE,
        SUM,
        SETUP,
        LOAD,
        DIV,
        WRITE,
        DONE
    } state_t;

    // Zero-extend one bin count into the running-sum width.
    function automatic cdf_t bin_to_cdf(input bin_t b);
        return CDF_W'(b);
    endfunction

endpackage

// File: rtl/hist_lut_builder_if.sv
// Histogram in / LUT-write out bundle between the builder and its neighbours.
interface hist_lut_builder_if;
    import hist_pkg::*;

    logic start;
    bin_t hist [NUM_BINS];
    logic hist_hold;
    logic busy;
    logic lut_we;
    pix_t lut_addr;
    pix_t lut_data;
    logic done;

    // Environment side: requests builds, supplies bins, consumes LUT writes.
    modport master (
        output start,
        output hist,
        input  hist_hold,
        input  busy,
        input  lut_we,
        input  lut_addr,
        input  lut_data,
        input  done
    );

    // Builder side.
    modport slave (
        input  start,
        input  hist,
        output hist_hold,
        output busy,
        output lut_we,
        output lut_addr,
        output lut_data,
        output done
    );
endinterface

// File: rtl/hist_lut_builder_div.sv
// 8-step restoring divider; valid for quotients below 256 (dividend < 256 * divisor).
// The first step is taken on the load edge so the quotient is final 8 cycles after load.
module div_restoring8
    import hist_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [NUM_W-1:0] i_dividend,
    input  cdf_t             i_divisor,
    output logic [7:0]       o_quotient,
    output logic             o_valid
);

    cdf_t         r_rem;
    logic [6:0]   r_dvd;
    logic [7:0]   r_quo;
    logic [2:0]   r_cnt;
    logic         r_valid;
    logic [CDF_W:0] w_trial;
    logic         w_qbit;
    cdf_t         w_rem_nxt;

    // One shared trial subtraction; the upper 24 dividend bits seed the remainder.
    always_comb begin
        w_trial   = i_load ? {i_dividend[NUM_W-1:8], i_dividend[7]} : {r_rem, r_dvd[6]};
        w_qbit    = (w_trial >= {1'b0, i_divisor});
        w_rem_nxt = w_qbit ? CDF_W'(w_trial - {1'b0, i_divisor}) : CDF_W'(w_trial);
    end

    // Remainder/quotient shift registers and step counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem   <= '0;
            r_dvd   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_rem   <= w_rem_nxt;
            r_dvd   <= i_dividend[6:0];
            r_quo   <= {7'd0, w_qbit};
            r_cnt   <= 3'd7;
            r_valid <= 1'b0;
        end else if (r_cnt != 3'd0) begin
            r_rem   <= w_rem_nxt;
            r_dvd   <= {r_dvd[5:0], 1'b0};
            r_quo   <= {r_quo[6:0], w_qbit};
            r_cnt   <= r_cnt - 3'd1;
            r_valid <= (r_cnt == 3'd1);
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign o_quotient = r_quo;
    assign o_valid    = r_valid;

endmodule

// File: rtl/hist_lut_builder.sv
// Histogram-equalization LUT builder: pass 1 sums bins and finds the first non-zero
// CDF, pass 2 writes one equalized level per bin (10 cycles per bin).
module hist_lut_builder
    import hist_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    hist_lut_builder_if.slave   bus
);

    state_t           r_state, w_state_nxt;
    pix_t             r_idx, w_idx_nxt;
    cdf_t             r_cdf, w_cdf_nxt;
    cdf_t             r_cdf_min, w_cdf_min_nxt;
    cdf_t             r_total, w_total_nxt;
    cdf_t             r_denom, w_denom_nxt;
    logic             r_ident, w_ident_nxt;
    logic             r_busy;
    logic             r_lut_we;
    logic             r_done;
    pix_t             r_lut_addr, w_lut_addr_nxt;
    pix_t             r_lut_data, w_lut_data_nxt;

    bin_t             w_bin;
    cdf_t             w_cdf_upd;
    logic [NUM_W-1:0] w_num;
    logic             w_div_load;
    logic [7:0]       w_quo;
    logic             w_div_valid;

    // Bin read mux, running sum and scaled numerator for the current bin.
    assign w_bin     = bus.hist[r_idx];
    assign w_cdf_upd = r_cdf + bin_to_cdf(w_bin);
    assign w_num     = (w_cdf_upd < r_cdf_min) ? '0
                     : NUM_W'(w_cdf_upd - r_cdf_min) * NUM_W'(MAX_LEVEL);

    div_restoring8 u_div (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_div_load),
        .i_dividend (w_num),
        .i_divisor  (r_denom),
        .o_quotient (w_quo),
        .o_valid    (w_div_valid)
    );

    // Next-state and datapath next values.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_cdf_nxt      = r_cdf;
        w_cdf_min_nxt  = r_cdf_min;
        w_total_nxt    = r_total;
        w_denom_nxt    = r_denom;
        w_ident_nxt    = r_ident;
        w_lut_addr_nxt = r_lut_addr;
        w_lut_data_nxt = r_lut_data;
        w_div_load     = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_idx_nxt     = '0;
                w_cdf_nxt     = '0;
                w_cdf_min_nxt = '0;
                if (bus.start) begin
                    w_state_nxt = SUM;
                end
            end
            SUM: begin
                w_cdf_nxt = w_cdf_upd;
                if ((r_cdf == '0) && (w_cdf_upd != '0)) begin
                    w_cdf_min_nxt = w_cdf_upd;
                end
                if (r_idx == PIX_W'(NUM_BINS - 1)) begin
                    w_total_nxt = w_cdf_upd;
                    w_state_nxt = SETUP;
                end else begin
                    w_idx_nxt = r_idx + PIX_W'(1);
                end
            end
            SETUP: begin
                w_denom_nxt = r_total - r_cdf_min;
                w_ident_nxt = (r_total == r_cdf_min);
                w_cdf_nxt   = '0;
                w_idx_nxt   = '0;
                w_state_nxt = LOAD;
            end
            LOAD: begin
                w_cdf_nxt   = w_cdf_upd;
                w_div_load  = 1'b1;
                w_state_nxt = DIV;
            end
            DIV: begin
                if (w_div_valid) begin
                    w_lut_addr_nxt = r_idx;
                    w_lut_data_nxt = r_ident ? r_idx : w_quo;
                    w_state_nxt    = WRITE;
                end
            end
            WRITE: begin
                if (r_idx == PIX_W'(NUM_BINS - 1)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_idx_nxt   = r_idx + PIX_W'(1);
                    w_state_nxt = LOAD;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_cdf      <= '0;
            r_cdf_min  <= '0;
            r_total    <= '0;
            r_denom    <= '0;
            r_ident    <= 1'b0;
            r_busy     <= 1'b0;
            r_lut_we   <= 1'b0;
            r_done     <= 1'b0;
            r_lut_addr <= '0;
            r_lut_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cdf      <= w_cdf_nxt;
            r_cdf_min  <= w_cdf_min_nxt;
            r_total    <= w_total_nxt;
            r_denom    <= w_denom_nxt;
            r_ident    <= w_ident_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_lut_we   <= (w_state_nxt == WRITE);
            r_done     <= (w_state_nxt == DONE);
            r_lut_addr <= w_lut_addr_nxt;
            r_lut_data <= w_lut_data_nxt;
        end
    end

    assign bus.hist_hold = r_busy;
    assign bus.busy      = r_busy;
    assign bus.lut_we    = r_lut_we;
    assign bus.lut_addr  = r_lut_addr;
    assign bus.lut_data  = r_lut_data;
    assign bus.done      = r_done;

endmodule

// File: doc/hist_lut_builder.md
# hist_lut_builder

Histogram-equalization LUT builder, downstream of the 256-bin histogram accumulator. On `start` it walks the 256 × 16-bit bin array twice. The first pass finds the total pixel count and the minimum non-zero CDF. The second pass streams one 8-bit equalized output level per bin to the LUT memory, which the pixel-remap stage then uses. While running it holds the accumulator frozen via `hist_hold`.

## Interface
- `BIN_W`, 16, width of one histogram bin.
- `CDF_W`, 24, running-sum width; holds 256 × (2^16−1) without overflow.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request a build; sampled only in IDLE.
- `hist`  in  [BIN_W-1:0] × [255:0] (unpacked)  bin counts from the accumulator; must stay stable while `busy`.
- `hist_hold`  out  1  equals `busy`; gates the accumulator's `we` low.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `lut_we`  out  1  one-cycle write strobe for the LUT memory.
- `lut_addr`  out  8  bin index being written.
- `lut_data`  out  8  equalized level for `lut_addr`.
- `done`  out  1  one-cycle pulse after the last LUT write.

## Operation
- Reset values: state IDLE; `busy`, `hist_hold`, `lut_we`, `done` = 0; `lut_addr`, `lut_data` = 0; all internal accumulators = 0.
- IDLE → SUM when `start` = 1. In IDLE, idx, cdf and cdf_min clear.
- SUM (256 cycles, idx 0..255):
  - cdf += hist[idx], zero-extended to CDF_W.
  - cdf_min is latched to the updated cdf in the first cycle where that cdf is non-zero.
  - After idx 255: total = cdf, then go to SETUP.
- SETUP (1 cycle):
  - denom = total − cdf_min.
  - ident = (denom == 0). This covers an empty histogram and a single-valued image.
  - Clear cdf and idx.
- MAP, per bin, 10 cycles:
  - LOAD (1): cdf += hist[idx]; num = (cdf < cdf_min) ? 0 : (cdf − cdf_min) × 255. num is 32 bits.
  - DIV (8): restoring division num / denom. The quotient is guaranteed ≤ 255 because num ≤ 255 × denom, so 8 steps suffice. The result is floor; no rounding.
  - WRITE (1): `lut_we` = 1, `lut_addr` = idx, `lut_data` = ident ? idx : quotient. If idx == 255 go to DONE, else idx++ and go to LOAD.
- DONE (1): `done` = 1, then IDLE.
- When ident = 1 the divider still runs (its result is discarded), so timing is identical in every case.
- `start` while busy is ignored; no queuing.
- `reset` mid-operation:
  - The next cycle is in IDLE with all outputs at reset values.
  - No further `lut_we` is issued; a partially written LUT is left as-is.
- Arithmetic is unsigned throughout. cdf cannot wrap: CDF_W = 24 covers the maximum of 16,776,960.

## Timing
- `start` is sampled at edge E0. SUM occupies cycles E0+1..E0+256, SETUP E0+257, MAP E0+258..E0+2817, DONE E0+2818, and IDLE resumes at E0+2819.
- `lut_we` pulses exactly 256 times, once every 10 cycles, starting at E0+267, with addresses ascending 0..255.
- `busy` / `hist_hold` are registered and high for cycles E0+1..E0+2818.
- `hist` is read combinationally through a 256:1 mux in SUM and LOAD only.

## Structure
- Package `hist_pkg`:
  - NUM_BINS = 256, BIN_W, CDF_W, PIX_W = 8.
  - State enum: IDLE, SUM, SETUP, LOAD, DIV, WRITE, DONE.
  - Typedef `bin_t` = logic [BIN_W-1:0].
  - This package is shared with the accumulator and the remap stage.
- Sub-module `div_restoring8`:
  - Inputs: 32-bit dividend, CDF_W-bit divisor, `load`.
  - Outputs: 8-bit quotient, `valid` 8 cycles after `load`.
  - Owns its own step counter.

## Test plan
- All bins 0 → ident path; lut[i] = i for i = 0..255; `done` at E0+2818; exactly 256 `lut_we` pulses.
- hist[i] = 1 for all i → total = 256, cdf_min = 1, denom = 255; lut[i] = i for all i.
- hist[10] = 4, hist[200] = 4, others 0 → cdf_min = 4, denom = 4; lut[0..199] = 0, lut[200..255] = 255.
- hist[50] = 100 only → denom = 0; identity LUT; no division artifacts.
- hist[0] = 65535, hist[255] = 65535 → cdf_min = 65535, denom = 65535; lut[0..254] = 0, lut[255] = 255. This checks that no overflow occurs in the 32-bit num path.
- Control checks:
  - Pulse `start` again at E0+500: ignored; output is unchanged.
  - Assert `reset` at E0+1000: `lut_we`, `busy` and `hist_hold` are 0 the next cycle.
  - A fresh `start` afterwards then produces the full correct LUT.
